// File: rtl/lfsr_rand_sched.sv
// Sequences the external serial LFSR (clear, seed, run), packs its bits into bytes and
// hands each byte to one requester by round-robin. Optional macro: LFSR_LOCKUP_CHECK_EN.
module lfsr_rand_sched #(
    parameter int unsigned NREQ         = 4,
    parameter logic [7:0]  SEED_DEFAULT = 8'hA5
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rand_data,
    output logic            rand_valid,
    input  logic            reseed,
    input  logic [7:0]      reseed_val,
    output logic            busy,
    output logic            lockup,
    output logic            lfsr_clr,
    output logic            lfsr_select,
    output logic [7:0]      lfsr_seed,
    input  logic            lfsr_out
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam logic [7:0] SeedInit = (SEED_DEFAULT == 8'h00) ? 8'h01 : SEED_DEFAULT;

    typedef enum logic [1:0] {StClear, StSeed, StRun} state_e;

    state_e          state;
    logic [6:0]      shift;
    logic [7:0]      pool;
    logic [7:0]      pending;
    logic [2:0]      bit_cnt;
    logic            pool_valid;
    logic [IdxW-1:0] last;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic            win_found;
    logic            lock_hit;
    logic            restart;
    logic            grant_fire;

    function automatic logic [7:0] nonzero(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    // Round-robin search starting just above the last granted index.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = IdxW'((int'(last) + i) % int'(NREQ));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign restart    = reseed | lock_hit;
    assign grant_fire = (state == StRun) && pool_valid && win_found && !restart;

`ifdef LFSR_LOCKUP_CHECK_EN
    // run_cnt holds the length of the current run of identical bits (0 = no bit seen yet).
    logic [3:0] run_cnt;
    logic       prev_bit;
    logic       lockup_q;

    assign lock_hit = (state == StRun) && (run_cnt == 4'd15) && (lfsr_out == prev_bit);
    assign lockup   = lockup_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            run_cnt  <= 4'd0;
            prev_bit <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            prev_bit <= lfsr_out;
            if (lock_hit) begin
                lockup_q <= 1'b1;
            end
            if (state != StRun || restart) begin
                run_cnt <= 4'd0;
            end else if (run_cnt == 4'd0 || lfsr_out != prev_bit) begin
                run_cnt <= 4'd1;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end
`else
    assign lock_hit = 1'b0;
    assign lockup   = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= StClear;
            lfsr_clr    <= 1'b1;
            lfsr_select <= 1'b0;
            lfsr_seed   <= 8'h00;
            busy        <= 1'b1;
            gnt         <= '0;
            rand_data   <= 8'h00;
            rand_valid  <= 1'b0;
            pending     <= SeedInit;
            pool_valid  <= 1'b0;
            pool        <= 8'h00;
            shift       <= 7'h00;
            bit_cnt     <= 3'd0;
            last        <= IdxW'(NREQ - 1);
        end else begin
            gnt         <= '0;
            rand_data   <= 8'h00;
            rand_valid  <= 1'b0;
            lfsr_clr    <= 1'b0;
            lfsr_select <= 1'b0;
            lfsr_seed   <= 8'h00;
            if (restart) begin
                // An explicit reseed value takes precedence over the lockup default.
                pending    <= reseed ? nonzero(reseed_val) : SeedInit;
                pool_valid <= 1'b0;
                state      <= StClear;
                lfsr_clr   <= 1'b1;
                busy       <= 1'b1;
            end else begin
                unique case (state)
                    StClear: begin
                        state       <= StSeed;
                        lfsr_select <= 1'b1;
                        lfsr_seed   <= pending;
                        busy        <= 1'b1;
                    end
                    StSeed: begin
                        state   <= StRun;
                        bit_cnt <= 3'd0;
                        busy    <= 1'b0;
                    end
                    StRun: begin
                        shift   <= {shift[5:0], lfsr_out};
                        bit_cnt <= bit_cnt + 3'd1;
                        // Load and grant never coincide: load needs an empty pool, grant a full one.
                        if (bit_cnt == 3'd7 && !pool_valid) begin
                            pool       <= {shift, lfsr_out};
                            pool_valid <= 1'b1;
                        end else if (grant_fire) begin
                            pool_valid <= 1'b0;
                        end
                        if (grant_fire) begin
                            gnt        <= NREQ'(1) << win_idx;
                            rand_data  <= pool;
                            rand_valid <= 1'b1;
                            last       <= win_idx;
                        end
                    end
                    default: begin
                        state <= StClear;
                    end
                endcase
            end
        end
    end

endmodule
